sad_line_array: RTL and testbench
=================================

SAD_LINE_ARRAY -- requirements
Module: sad_line_array

Interface
REQ-001 Parameter N, default 8: number of processing elements (current-row pixels compared per window), N >= 2.
REQ-002 Parameter PW, default 8: pixel width in bits.
REQ-003 Parameter POSW, default 8: width of window position index.
REQ-004 Derived RW = PW + clog2(N): SAD result width (11 for defaults).
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 line_start  in  1  pulse: latch current row, begin new search line.
REQ-008 line_end  in  1  pulse: last reference pixel of line has been (or is being) supplied.
REQ-009 data_in_cur  in  N*PW  packed current-row pixels, pixel i at bits [i*PW +: PW].
REQ-010 data_in_ref  in  PW  reference pixel stream.
REQ-011 ref_valid  in  1  data_in_ref valid this cycle.
REQ-012 result_reg  out  RW  SAD of one candidate window.
REQ-013 result_valid  out  1  result_reg/result_pos valid this cycle.
REQ-014 result_pos  out  POSW  window index of result_reg since line_start.
REQ-015 best_sad  out  RW  minimum SAD of completed line.
REQ-016 best_pos  out  POSW  position of best_sad.
REQ-017 best_valid  out  1  one-cycle pulse: best_sad/best_pos final.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, FILL, RUN, DRAIN; IDLE after reset.
REQ-020 line_start in any state: latch data_in_cur, clear fill count, window index, all pipeline valids, best_sad to all-ones, best_pos to 0; go to FILL.
REQ-021 FILL/RUN: each ref_valid beat shifts data_in_ref into an N-deep window, newest at element N-1, oldest at element 0.
REQ-022 FILL -> RUN on the ref_valid beat that is the Nth accepted since line_start; that beat completes window 0.
REQ-023 In RUN every ref_valid beat completes one window; window index increments per window, wraps modulo 2^POSW.
REQ-024 Window SAD = sum over i of |cur_i - win_i|, unsigned, computed at full RW width, never saturates or overflows.
REQ-025 Pipeline: stage 1 registers N absolute differences, stage 2 registers sum; result_valid rises exactly 2 cycles after the completing ref_valid edge.
REQ-026 ref_valid gaps stall nothing downstream; results already in flight still emerge on schedule.
REQ-027 ref_valid in IDLE or DRAIN is ignored.
REQ-028 line_end in FILL or RUN -> DRAIN; a ref_valid beat in the same cycle is processed first.
REQ-029 DRAIN lasts until both pipeline stages are empty, then best_valid pulses one cycle and FSM returns to IDLE.
REQ-030 line_end with no completed windows: best_valid still pulses with best_sad all-ones, best_pos 0.
REQ-031 line_start and line_end in the same cycle: line_start wins, line_end ignored.
REQ-032 best_sad/best_pos hold their values from best_valid until next line_start or reset.

Reset
REQ-033 rst low asynchronously forces IDLE, clears window, fill count, index, pipeline valids, all outputs to 0 (best_sad to 0).
REQ-034 Reset mid-line discards all in-flight results; no result_valid or best_valid after rst rises until a new line_start.

Configuration
REQ-035 Macro SAD_MIN_TRACK_EN defined: each result_valid result with result_reg strictly less than best_sad updates best_sad/best_pos; ties keep the earlier position.
REQ-036 Macro undefined: comparator and best registers are not built; best_sad, best_pos tied to 0, best_valid still pulses at end of DRAIN.

Verification
REQ-037 N=8,PW=8: line_start with all cur=1, 12 beats ref=0 -> first result_valid 2 cycles after 8th beat, 5 results of 11'd8, result_pos 0..4.
REQ-038 All cur=255, ref=0 -> result_reg=2040, no overflow.
REQ-039 cur=3..10, ref ramp 0,1,2,...,15, MIN_TRACK_EN -> result at pos 3 is 0, best_sad 0, best_pos 3 on best_valid.
REQ-040 Ref stream with equal minima at pos 1 and pos 4 -> best_pos 1.
REQ-041 line_end after 5 beats (FILL) -> no result_valid, best_valid with best_sad 2047, best_pos 0.
REQ-042 rst low during RUN with 2 results in flight -> outputs 0 immediately, no stray result_valid after release, busy 0.

Source files
------------

// File: rtl/sad_line_array.sv
// sad_line_array: sum-of-absolute-differences search along one image line.
// A current-row block of N pixels is latched on line_start. Each accepted
// reference pixel then shifts into an N-deep window, and every complete window
// produces one SAD result through a two-stage pipeline.
// Optional feature macro: SAD_MIN_TRACK_EN builds running-minimum tracking
// (best_sad/best_pos). Without it, best_sad/best_pos are tied to zero.
module sad_line_array #(
    parameter  int N    = 8,
    parameter  int PW   = 8,
    parameter  int POSW = 8,
    localparam int RW   = PW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic              line_end,
    input  logic [N*PW-1:0]   data_in_cur,
    input  logic [PW-1:0]     data_in_ref,
    input  logic              ref_valid,
    output logic [RW-1:0]     result_reg,
    output logic              result_valid,
    output logic [POSW-1:0]   result_pos,
    output logic [RW-1:0]     best_sad,
    output logic [POSW-1:0]   best_pos,
    output logic              best_valid,
    output logic              busy
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   cur_q [N];
    logic [PW-1:0]   win   [N];
    logic [PW-1:0]   diff  [N];
    logic [CW-1:0]   fill_cnt;
    logic [POSW-1:0] win_idx;
    logic [POSW-1:0] w_pos;
    logic [POSW-1:0] s1_pos;
    logic            w_valid;
    logic            s1_valid;
    logic            take_beat;
    logic            complete;
    logic            drain_done;
    logic [RW-1:0]   sad_sum;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode; line_start overrides everything, including line_end
    always_comb begin
        next_state = state;
        take_beat  = 1'b0;
        drain_done = 1'b0;
        complete   = 1'b0;
        if (line_start) begin
            next_state = FILL;
        end else begin
            case (state)
                IDLE: next_state = IDLE;
                FILL, RUN: begin
                    take_beat = ref_valid;
                    if (ref_valid && state == FILL && fill_cnt == CW'(N - 1))
                        next_state = RUN;
                    if (line_end)
                        next_state = DRAIN;
                end
                DRAIN: begin
                    if (!w_valid && !s1_valid && !result_valid) begin
                        drain_done = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
            complete = take_beat && (state == RUN || fill_cnt == CW'(N - 1));
        end
    end

    // Current-row capture, reference window shift and window bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                cur_q[i] <= '0;
                win[i]   <= '0;
            end
            fill_cnt <= '0;
            win_idx  <= '0;
            w_valid  <= 1'b0;
            w_pos    <= '0;
        end else if (line_start) begin
            for (int unsigned i = 0; i < N; i++)
                cur_q[i] <= data_in_cur[i*PW +: PW];
            fill_cnt <= '0;
            win_idx  <= '0;
            w_valid  <= 1'b0;
        end else begin
            w_valid <= complete;
            if (take_beat) begin
                for (int unsigned i = 0; i < N - 1; i++)
                    win[i] <= win[i+1];
                win[N-1] <= data_in_ref;
                if (complete) begin
                    w_pos   <= win_idx;
                    win_idx <= win_idx + POSW'(1);
                end else begin
                    fill_cnt <= fill_cnt + CW'(1);
                end
            end
        end
    end

    // Stage 1: per-element absolute differences of the completed window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) diff[i] <= '0;
            s1_valid <= 1'b0;
            s1_pos   <= '0;
        end else if (line_start) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= w_valid;
            if (w_valid) begin
                for (int unsigned i = 0; i < N; i++)
                    diff[i] <= (cur_q[i] > win[i]) ? (cur_q[i] - win[i])
                                                   : (win[i] - cur_q[i]);
                s1_pos <= w_pos;
            end
        end
    end

    // Adder tree at full result width so the sum can never wrap
    always_comb begin
        sad_sum = '0;
        for (int unsigned i = 0; i < N; i++)
            sad_sum = sad_sum + RW'(diff[i]);
    end

    // Stage 2: registered SAD result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid <= 1'b0;
            result_reg   <= '0;
            result_pos   <= '0;
        end else if (line_start) begin
            result_valid <= 1'b0;
        end else begin
            result_valid <= s1_valid;
            if (s1_valid) begin
                result_reg <= sad_sum;
                result_pos <= s1_pos;
            end
        end
    end

    // End-of-line pulse once the drain has flushed both pipeline stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) best_valid <= 1'b0;
        else      best_valid <= drain_done;
    end

`ifdef SAD_MIN_TRACK_EN
    // Running minimum; strict compare keeps the earliest position on ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_sad <= '0;
            best_pos <= '0;
        end else if (line_start) begin
            best_sad <= '1;
            best_pos <= '0;
        end else if (result_valid && result_reg < best_sad) begin
            best_sad <= result_reg;
            best_pos <= result_pos;
        end
    end
`else
    assign best_sad = '0;
    assign best_pos = '0;
`endif

endmodule

// File: tb/tb_sad_line_array.sv
// Directed testbench for sad_line_array (N=8, PW=8, POSW=8).
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_sad_line_array;
    localparam int N    = 8;
    localparam int PW   = 8;
    localparam int POSW = 8;
    localparam int RW   = 11;

`ifdef SAD_MIN_TRACK_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            line_start = 1'b0;
    logic            line_end = 1'b0;
    logic            ref_valid = 1'b0;
    logic [N*PW-1:0] data_in_cur = '0;
    logic [PW-1:0]   data_in_ref = '0;
    logic [RW-1:0]   result_reg;
    logic            result_valid;
    logic [POSW-1:0] result_pos;
    logic [RW-1:0]   best_sad;
    logic [POSW-1:0] best_pos;
    logic            best_valid;
    logic            busy;

    int errors = 0;
    int checks = 0;

    sad_line_array #(.N(N), .PW(PW), .POSW(POSW)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_end(line_end),
        .data_in_cur(data_in_cur), .data_in_ref(data_in_ref), .ref_valid(ref_valid),
        .result_reg(result_reg), .result_valid(result_valid), .result_pos(result_pos),
        .best_sad(best_sad), .best_pos(best_pos), .best_valid(best_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs and return just after the rising edge
    task automatic cyc(input logic ls, input logic le, input logic rv, input logic [PW-1:0] rf);
        @(negedge clk);
        line_start  = ls;
        line_end    = le;
        ref_valid   = rv;
        data_in_ref = rf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ref_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, result_valid, best_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {busy, result_valid, best_valid});
        end
        checks++;
        if (result_reg !== '0 || result_pos !== '0 || best_sad !== '0 || best_pos !== '0) begin
            errors++; $display("FAIL reset_data got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                               result_reg, result_pos, best_sad, best_pos);
        end
        @(negedge clk) rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'd5);
            checks++;
            if ({busy, result_valid, best_valid} !== 3'b000) begin
                errors++; $display("FAIL idle_ref_ignored t=%0d got=%b exp=000", t, {busy, result_valid, best_valid});
            end
        end
    endtask

    task automatic test_basic();
        logic exp_rv;
        data_in_cur = {N{8'd1}};
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL basic_start busy=%b rv=%b exp=1/0", busy, result_valid);
        end
        for (int t = 0; t <= 16; t++) begin
            cyc(1'b0, (t == 11), (t <= 11), 8'd0);
            exp_rv = (t >= 9 && t <= 13);
            checks++;
            if (result_valid !== exp_rv) begin
                errors++; $display("FAIL basic_valid t=%0d got=%b exp=%b", t, result_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (result_reg !== 11'd8 || result_pos !== POSW'(t - 9)) begin
                    errors++; $display("FAIL basic_result t=%0d got=%0d@%0d exp=8@%0d", t, result_reg, result_pos, t - 9);
                end
            end
            checks++;
            if (best_valid !== (t == 15)) begin
                errors++; $display("FAIL basic_best_valid t=%0d got=%b exp=%b", t, best_valid, (t == 15));
            end
            if (t == 15) begin
                checks++;
                if (best_sad !== (MIN_EN ? 11'd8 : 11'd0) || best_pos !== '0 || busy !== 1'b0) begin
                    errors++; $display("FAIL basic_best got=%0d@%0d busy=%b exp=%0d@0 busy=0",
                                       best_sad, best_pos, busy, MIN_EN ? 8 : 0);
                end
            end
        end
    endtask

    task automatic test_no_overflow();
        data_in_cur = {N{8'd255}};
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t <= 12; t++) begin
            cyc(1'b0, (t == 7), (t <= 7), 8'd0);
            checks++;
            if (result_valid !== (t == 9)) begin
                errors++; $display("FAIL ovf_valid t=%0d got=%b exp=%b", t, result_valid, (t == 9));
            end
            if (t == 9) begin
                checks++;
                if (result_reg !== 11'd2040 || result_pos !== '0) begin
                    errors++; $display("FAIL ovf_result got=%0d@%0d exp=2040@0", result_reg, result_pos);
                end
            end
            checks++;
            if (best_valid !== (t == 11)) begin
                errors++; $display("FAIL ovf_best_valid t=%0d got=%b exp=%b", t, best_valid, (t == 11));
            end
            if (t == 11) begin
                checks++;
                if (best_sad !== (MIN_EN ? 11'd2040 : 11'd0) || best_pos !== '0) begin
                    errors++; $display("FAIL ovf_best got=%0d@%0d exp=%0d@0", best_sad, best_pos, MIN_EN ? 2040 : 0);
                end
            end
        end
    endtask

    task automatic test_ramp_min();
        int k;
        logic exp_rv;
        for (int i = 0; i < N; i++) data_in_cur[i*PW +: PW] = PW'(3 + i);
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t <= 21; t++) begin
            cyc(1'b0, (t == 15), (t <= 15), PW'(t));
            k = t - 9;
            exp_rv = (t >= 9 && t <= 17);
            checks++;
            if (result_valid !== exp_rv) begin
                errors++; $display("FAIL ramp_valid t=%0d got=%b exp=%b", t, result_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (result_reg !== RW'(8 * ((k > 3) ? (k - 3) : (3 - k))) || result_pos !== POSW'(k)) begin
                    errors++; $display("FAIL ramp_result pos=%0d got=%0d@%0d exp=%0d", k, result_reg, result_pos,
                                       8 * ((k > 3) ? (k - 3) : (3 - k)));
                end
            end
            checks++;
            if (best_valid !== (t == 19)) begin
                errors++; $display("FAIL ramp_best_valid t=%0d got=%b exp=%b", t, best_valid, (t == 19));
            end
            if (t == 19 || t == 21) begin
                checks++;
                if (best_sad !== '0 || best_pos !== (MIN_EN ? 8'd3 : 8'd0)) begin
                    errors++; $display("FAIL ramp_best t=%0d got=%0d@%0d exp=0@%0d", t, best_sad, best_pos, MIN_EN ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_tie();
        int refs [12] = '{20, 0, 0, 5, 1, 1, 1, 1, 1, 5, 0, 0};
        int sads [5]  = '{29, 10, 15, 15, 10};
        logic exp_rv;
        data_in_cur = '0;
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t <= 16; t++) begin
            cyc(1'b0, (t == 11), (t <= 11), (t <= 11) ? PW'(refs[t]) : 8'd0);
            exp_rv = (t >= 9 && t <= 13);
            checks++;
            if (result_valid !== exp_rv) begin
                errors++; $display("FAIL tie_valid t=%0d got=%b exp=%b", t, result_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (result_reg !== RW'(sads[t-9]) || result_pos !== POSW'(t - 9)) begin
                    errors++; $display("FAIL tie_result pos=%0d got=%0d exp=%0d", t - 9, result_reg, sads[t-9]);
                end
            end
            if (t == 15) begin
                checks++;
                if (best_valid !== 1'b1 || best_sad !== (MIN_EN ? 11'd10 : 11'd0) || best_pos !== (MIN_EN ? 8'd1 : 8'd0)) begin
                    errors++; $display("FAIL tie_best bv=%b got=%0d@%0d exp=%0d@%0d", best_valid, best_sad, best_pos,
                                       MIN_EN ? 10 : 0, MIN_EN ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic exp_rv;
        logic rv;
        logic [PW-1:0] rf;
        data_in_cur = {N{8'd1}};
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t <= 17; t++) begin
            rv = (t <= 7) || (t == 9) || (t == 12);
            rf = (t == 9) ? 8'd1 : ((t == 12) ? 8'd3 : 8'd0);
            cyc(1'b0, (t == 12), rv, rf);
            exp_rv = (t == 9) || (t == 11) || (t == 14);
            checks++;
            if (result_valid !== exp_rv) begin
                errors++; $display("FAIL gap_valid t=%0d got=%b exp=%b", t, result_valid, exp_rv);
            end
            if (t == 9 || t == 11 || t == 14) begin
                checks++;
                if (result_reg !== ((t == 11) ? 11'd7 : 11'd8) ||
                    result_pos !== ((t == 9) ? 8'd0 : ((t == 11) ? 8'd1 : 8'd2))) begin
                    errors++; $display("FAIL gap_result t=%0d got=%0d@%0d", t, result_reg, result_pos);
                end
            end
            checks++;
            if (best_valid !== (t == 16)) begin
                errors++; $display("FAIL gap_best_valid t=%0d got=%b exp=%b", t, best_valid, (t == 16));
            end
            if (t == 16) begin
                checks++;
                if (best_sad !== (MIN_EN ? 11'd7 : 11'd0) || best_pos !== (MIN_EN ? 8'd1 : 8'd0)) begin
                    errors++; $display("FAIL gap_best got=%0d@%0d exp=%0d@%0d", best_sad, best_pos,
                                       MIN_EN ? 7 : 0, MIN_EN ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_fill_end();
        data_in_cur = {N{8'd9}};
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t <= 7; t++) begin
            cyc(1'b0, (t == 5), (t <= 4), 8'd4);
            checks++;
            if (result_valid !== 1'b0 || best_valid !== (t == 6)) begin
                errors++; $display("FAIL fill_end_flags t=%0d rv=%b bv=%b exp=0/%b", t, result_valid, best_valid, (t == 6));
            end
            if (t == 6) begin
                checks++;
                if (best_sad !== (MIN_EN ? 11'd2047 : 11'd0) || best_pos !== '0 || busy !== 1'b0) begin
                    errors++; $display("FAIL fill_end_best got=%0d@%0d busy=%b exp=%0d@0 busy=0",
                                       best_sad, best_pos, busy, MIN_EN ? 2047 : 0);
                end
            end
        end
    endtask

    task automatic test_start_priority();
        data_in_cur = {N{8'd1}};
        cyc(1'b1, 1'b1, 1'b0, 8'd0);
        checks++;
        if (busy !== 1'b1 || best_valid !== 1'b0) begin
            errors++; $display("FAIL prio_start busy=%b bv=%b exp=1/0", busy, best_valid);
        end
        for (int t = 0; t <= 12; t++) begin
            cyc((t == 8), (t == 11), (t <= 7), 8'd2);
            checks++;
            if (result_valid !== 1'b0) begin
                errors++; $display("FAIL prio_flush t=%0d rv=%b exp=0", t, result_valid);
            end
            checks++;
            if (best_valid !== (t == 12) || busy !== (t != 12)) begin
                errors++; $display("FAIL prio_state t=%0d bv=%b busy=%b exp=%b/%b", t, best_valid, busy, (t == 12), (t != 12));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        data_in_cur = {N{8'd1}};
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t <= 9; t++) cyc(1'b0, 1'b0, 1'b1, 8'd0);
        checks++;
        if (result_valid !== 1'b1 || result_pos !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre rv=%b pos=%0d busy=%b exp=1/0/1", result_valid, result_pos, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, result_valid, best_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_async_flags got=%b exp=000", {busy, result_valid, best_valid});
        end
        checks++;
        if (result_reg !== '0 || result_pos !== '0 || best_sad !== '0 || best_pos !== '0) begin
            errors++; $display("FAIL rst_async_data got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                               result_reg, result_pos, best_sad, best_pos);
        end
        @(negedge clk) rst = 1'b1;
        for (int t = 0; t < 5; t++) begin
            cyc(1'b0, (t == 2), 1'b1, 8'd0);
            checks++;
            if ({busy, result_valid, best_valid} !== 3'b000) begin
                errors++; $display("FAIL rst_after t=%0d got=%b exp=000", t, {busy, result_valid, best_valid});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_overflow();
        test_ramp_min();
        test_tie();
        test_gaps();
        test_fill_end();
        test_start_priority();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
